// File: rtl/vend_credit_ctrl_if.sv
// Signal bundle between the credit controller, the credit register and the
// coin / dispense / payout blocks. master = controller side.
interface vend_credit_ctrl_if #(
    parameter int WIDTH = 5
);
    logic             coin_valid;
    logic [1:0]       coin_val;
    logic             coin_ready;
    logic             coin_reject;
    logic             vend_req;
    logic             cancel;
    logic             vend_out;
    logic             vend_deny;
    logic             change_valid;
    logic [WIDTH-1:0] change_amt;
    logic             change_ack;
    logic             reg_load;
    logic             reg_clear;
    logic [WIDTH-1:0] reg_d;
    logic [WIDTH-1:0] reg_q;

    modport master (
        input  coin_valid, coin_val, vend_req, cancel, change_ack, reg_q,
        output coin_ready, coin_reject, vend_out, vend_deny,
               change_valid, change_amt, reg_load, reg_clear, reg_d
    );

    modport slave (
        output coin_valid, coin_val, vend_req, cancel, change_ack, reg_q,
        input  coin_ready, coin_reject, vend_out, vend_deny,
               change_valid, change_amt, reg_load, reg_clear, reg_d
    );
endinterface

// File: rtl/vend_credit_ctrl.sv
// Vending credit controller: sequences the external credit register for coins,
// vends and refunds. Optional idle auto-refund enabled by CREDIT_TIMEOUT_EN.
module vend_credit_ctrl #(
    parameter int WIDTH          = 5,
    parameter int PRICE          = 15,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    vend_credit_ctrl_if.master  bus
);

    typedef enum logic [2:0] {INIT, IDLE, SETTLE, VEND, CHANGE} state_t;

    state_t           state_q, state_d;
    logic             vend_out_q, vend_out_d;
    logic             vend_deny_q, vend_deny_d;
    logic             change_valid_q, change_valid_d;
    logic [WIDTH-1:0] change_amt_q, change_amt_d;
    logic             reg_load, reg_clear, coin_ready, coin_reject;
    logic [WIDTH-1:0] reg_d;
    logic [WIDTH:0]   coin_sum;
    logic             timeout_hit;

    function automatic logic [WIDTH:0] coin_value(input logic [1:0] code);
        case (code)
            2'b00:   return (WIDTH+1)'(1);
            2'b01:   return (WIDTH+1)'(2);
            2'b10:   return (WIDTH+1)'(5);
            default: return (WIDTH+1)'(10);
        endcase
    endfunction

`ifdef CREDIT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_cnt_q, idle_cnt_d;

    // Counts only quiet IDLE cycles holding credit; anything else restarts it.
    always_comb begin
        idle_cnt_d  = '0;
        timeout_hit = 1'b0;
        if (state_q == IDLE && !bus.cancel && !bus.vend_req && !bus.coin_valid &&
            bus.reg_q != '0) begin
            if (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1))
                timeout_hit = 1'b1;
            else
                idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle_cnt_q <= '0;
        else
            idle_cnt_q <= idle_cnt_d;
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch.
        state_d        = state_q;
        vend_out_d     = 1'b0;
        vend_deny_d    = 1'b0;
        change_valid_d = change_valid_q;
        change_amt_d   = change_amt_q;
        reg_load       = 1'b0;
        reg_clear      = 1'b0;
        reg_d          = '0;
        coin_ready     = 1'b0;
        coin_reject    = 1'b0;
        coin_sum       = {1'b0, bus.reg_q} + coin_value(bus.coin_val);

        case (state_q)
            INIT: begin
                // Gated so reg_clear stays low while reset is held.
                reg_clear = rst_n;
                state_d   = IDLE;
            end
            IDLE: begin
                coin_ready = !bus.cancel && !bus.vend_req;
                if (bus.cancel || timeout_hit) begin
                    if (bus.reg_q != '0) begin
                        change_amt_d   = bus.reg_q;
                        change_valid_d = 1'b1;
                        state_d        = CHANGE;
                    end
                end else if (bus.vend_req) begin
                    if (bus.reg_q >= WIDTH'(PRICE)) begin
                        change_amt_d = bus.reg_q - WIDTH'(PRICE);
                        vend_out_d   = 1'b1;
                        state_d      = VEND;
                    end else begin
                        vend_deny_d = 1'b1;
                    end
                end else if (bus.coin_valid) begin
                    if (!coin_sum[WIDTH]) begin
                        reg_load = 1'b1;
                        reg_d    = coin_sum[WIDTH-1:0];
                        state_d  = SETTLE;
                    end else begin
                        coin_reject = 1'b1;
                    end
                end
            end
            SETTLE: state_d = IDLE;
            VEND: begin
                if (change_amt_q != '0) begin
                    reg_load       = 1'b1;
                    reg_d          = change_amt_q;
                    change_valid_d = 1'b1;
                    state_d        = CHANGE;
                end else begin
                    reg_clear = 1'b1;
                    state_d   = IDLE;
                end
            end
            CHANGE: begin
                if (bus.change_ack) begin
                    reg_clear      = 1'b1;
                    change_valid_d = 1'b0;
                    change_amt_d   = '0;
                    state_d        = IDLE;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // NOTE: state and registered outputs update with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= INIT;
            vend_out_q     <= 1'b0;
            vend_deny_q    <= 1'b0;
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;
        end else begin
            state_q        <= state_d;
            vend_out_q     <= vend_out_d;
            vend_deny_q    <= vend_deny_d;
            change_valid_q <= change_valid_d;
            change_amt_q   <= change_amt_d;
        end
    end

    assign bus.coin_ready   = coin_ready;
    assign bus.coin_reject  = coin_reject;
    assign bus.reg_load     = reg_load;
    assign bus.reg_clear    = reg_clear;
    assign bus.reg_d        = reg_d;
    assign bus.vend_out     = vend_out_q;
    assign bus.vend_deny    = vend_deny_q;
    assign bus.change_valid = change_valid_q;
    assign bus.change_amt   = change_amt_q;

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Self-checking bench for vend_credit_ctrl: directed table, reset/timeout
// sequences and random transactions against a credit-level reference model.
module tb_vend_credit_ctrl;

    localparam int WIDTH = 5;
    localparam int PRICE = 15;
    localparam int TMO   = 8;
    localparam int MAXC  = 31;

    typedef enum int {K_COIN, K_VEND, K_CANCEL} kind_t;
    typedef struct {
        kind_t      kind;
        logic [1:0] cv;
        bit         with_other;
        int         exp_credit;
    } vec_t;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] credit_reg = 5'd19;
    int               n_vec = 0;
    int               n_bad = 0;
    int               mutex_err = 0;
    int               credit = 0;
    vec_t             tbl[22];

    vend_credit_ctrl_if #(.WIDTH(WIDTH)) bus();

    vend_credit_ctrl #(.WIDTH(WIDTH), .PRICE(PRICE), .TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // External credit register: no reset of its own.
    assign bus.reg_q = credit_reg;
    always @(posedge clk) begin
        if (bus.reg_clear)     credit_reg <= '0;
        else if (bus.reg_load) credit_reg <= bus.reg_d;
    end

    always @(negedge clk) if (bus.reg_clear && bus.reg_load) mutex_err++;

    function automatic int coin_units(input logic [1:0] c);
        case (c)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 5;
            default: return 10;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.coin_valid = 1'b0;
        bus.coin_val   = 2'b00;
        bus.vend_req   = 1'b0;
        bus.cancel     = 1'b0;
        bus.change_ack = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vend_out"},     bus.vend_out, 0);
        check({tag, "_vend_deny"},    bus.vend_deny, 0);
        check({tag, "_change_valid"}, bus.change_valid, 0);
        check({tag, "_change_amt"},   bus.change_amt, 0);
        check({tag, "_reg_load"},     bus.reg_load, 0);
        check({tag, "_reg_clear"},    bus.reg_clear, 0);
        check({tag, "_reg_d"},        bus.reg_d, 0);
        check({tag, "_coin_ready"},   bus.coin_ready, 0);
        check({tag, "_coin_reject"},  bus.coin_reject, 0);
    endtask

    task automatic wait_idle();
        bit found = 1'b0;
        idle_inputs();
        for (int i = 0; i < 16 && !found; i++) begin
            @(negedge clk); #1;
            found = bus.coin_ready;
        end
        check("reach_idle", found, 1);
    endtask

    task automatic do_change(input int amt);
        bit seen = 1'b0;
        int hold;
        for (int i = 0; i < 4 && !seen; i++) begin
            if (bus.change_valid) seen = 1'b1;
            else begin @(negedge clk); #1; end
        end
        check("change_valid_up", seen, 1);
        check("change_amt", bus.change_amt, amt);
        hold = $urandom_range(0, 3);
        repeat (hold) begin
            @(negedge clk);
            bus.coin_valid = 1'b1;
            bus.cancel     = 1'($urandom_range(0, 1));
            #1;
            check("change_hold_valid", bus.change_valid, 1);
            check("change_hold_amt", bus.change_amt, amt);
            check("change_coin_ready", bus.coin_ready, 0);
            check("change_no_load", bus.reg_load, 0);
        end
        @(negedge clk);
        idle_inputs();
        bus.change_ack = 1'b1;
        #1;
        check("ack_clear", bus.reg_clear, 1);
        @(posedge clk); #1;
        check("ack_valid_drop", bus.change_valid, 0);
        check("ack_amt_zero", bus.change_amt, 0);
        @(negedge clk);
        bus.change_ack = 1'b0;
    endtask

    // One transaction, checked against the credit-level model in 'credit'.
    task automatic apply_op(input kind_t kind, input logic [1:0] cv, input bit other,
                            input bit stray);
        int v = coin_units(cv);
        int exp_change = 0;
        bit need_change = 1'b0;
        bit accepted = (kind == K_COIN) && (credit + v <= MAXC);
        bit do_vend  = (kind == K_VEND) && (credit >= PRICE);

        wait_idle();
        bus.change_ack = stray;
        bus.coin_val   = cv;
        case (kind)
            K_COIN: bus.coin_valid = 1'b1;
            K_VEND: begin bus.vend_req = 1'b1; bus.coin_valid = other; end
            default: begin bus.cancel = 1'b1; bus.vend_req = other; bus.coin_valid = other; end
        endcase
        #1;
        check("coin_ready", bus.coin_ready, kind == K_COIN);
        check("reg_load", bus.reg_load, accepted);
        check("coin_reject", bus.coin_reject, (kind == K_COIN) && !accepted);
        check("reg_clear_idle", bus.reg_clear, 0);
        if (accepted) check("reg_d_sum", bus.reg_d, credit + v);
        @(posedge clk); #1;
        check("vend_out", bus.vend_out, do_vend);
        check("vend_deny", bus.vend_deny, (kind == K_VEND) && !do_vend);
        @(negedge clk);
        if (accepted) begin
            bus.change_ack = 1'b0;
            #1;
            check("settle_ready", bus.coin_ready, 0);
            check("settle_no_load", bus.reg_load, 0);
            idle_inputs();
            @(negedge clk); #1;
            check("settle_one_cycle", bus.coin_ready, 1);
            credit += v;
        end else begin
            idle_inputs();
            #1;
        end
        if (do_vend) begin
            exp_change = credit - PRICE;
            check("vend_load", bus.reg_load, exp_change != 0);
            check("vend_clear", bus.reg_clear, exp_change == 0);
            if (exp_change != 0) check("vend_reg_d", bus.reg_d, exp_change);
            @(posedge clk); #1;
            check("vend_one_pulse", bus.vend_out, 0);
            if (exp_change == 0) check("no_change", bus.change_valid, 0);
            need_change = (exp_change != 0);
            credit = 0;
        end
        if (kind == K_VEND && !do_vend) begin
            @(posedge clk); #1;
            check("deny_one_pulse", bus.vend_deny, 0);
        end
        if (kind == K_CANCEL && credit != 0) begin
            exp_change  = credit;
            need_change = 1'b1;
            credit      = 0;
        end
        if (need_change) do_change(exp_change);
        wait_idle();
        check("credit", credit_reg, credit);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int    r;
        kind_t k;
        bit    seen;

        tbl[0]  = '{K_COIN,   2'b11, 1'b0, 10};
        tbl[1]  = '{K_COIN,   2'b10, 1'b0, 15};
        tbl[2]  = '{K_VEND,   2'b00, 1'b0, 0};
        tbl[3]  = '{K_COIN,   2'b11, 1'b0, 10};
        tbl[4]  = '{K_COIN,   2'b11, 1'b0, 20};
        tbl[5]  = '{K_VEND,   2'b00, 1'b0, 0};
        tbl[6]  = '{K_COIN,   2'b11, 1'b0, 10};
        tbl[7]  = '{K_COIN,   2'b11, 1'b0, 20};
        tbl[8]  = '{K_COIN,   2'b11, 1'b0, 30};
        tbl[9]  = '{K_COIN,   2'b01, 1'b0, 30};
        tbl[10] = '{K_COIN,   2'b00, 1'b0, 31};
        tbl[11] = '{K_VEND,   2'b00, 1'b0, 0};
        tbl[12] = '{K_COIN,   2'b11, 1'b0, 10};
        tbl[13] = '{K_COIN,   2'b01, 1'b0, 12};
        tbl[14] = '{K_VEND,   2'b00, 1'b0, 12};
        tbl[15] = '{K_CANCEL, 2'b00, 1'b0, 0};
        tbl[16] = '{K_CANCEL, 2'b00, 1'b0, 0};
        tbl[17] = '{K_COIN,   2'b10, 1'b0, 5};
        tbl[18] = '{K_CANCEL, 2'b11, 1'b1, 0};
        tbl[19] = '{K_COIN,   2'b00, 1'b0, 1};
        tbl[20] = '{K_VEND,   2'b11, 1'b1, 1};
        tbl[21] = '{K_CANCEL, 2'b00, 1'b0, 0};

        idle_inputs();
        rst_n = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("init_clear", bus.reg_clear, 1);
        check("init_coin_ready", bus.coin_ready, 0);
        @(negedge clk); #1;
        check("init_one_cycle", bus.reg_clear, 0);
        check("init_credit", credit_reg, 0);
        credit = 0;

        foreach (tbl[i]) begin
            apply_op(tbl[i].kind, tbl[i].cv, tbl[i].with_other, 1'b0);
            check("table_credit", credit_reg, tbl[i].exp_credit);
        end

        // Reset while a refund of 7 is pending.
        apply_op(K_COIN, 2'b10, 1'b0, 1'b0);
        apply_op(K_COIN, 2'b01, 1'b0, 1'b0);
        wait_idle();
        bus.cancel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        #1;
        check("pre_rst_valid", bus.change_valid, 1);
        check("pre_rst_amt", bus.change_amt, 7);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_init_clear", bus.reg_clear, 1);
        @(negedge clk); #1;
        check("rst_credit", credit_reg, 0);
        check("rst_idle", bus.coin_ready, 1);
        credit = 0;

        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            k = (r < 6) ? K_COIN : ((r < 8) ? K_VEND : K_CANCEL);
            apply_op(k, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 3) == 0));
        end

        if (credit != 0) apply_op(K_CANCEL, 2'b00, 1'b0, 1'b0);
        apply_op(K_COIN, 2'b10, 1'b0, 1'b0);
`ifdef CREDIT_TIMEOUT_EN
        seen = 1'b0;
        for (int i = 0; i < TMO + 6 && !seen; i++) begin
            @(negedge clk); #1;
            seen = bus.change_valid;
        end
        check("timeout_refund", seen, 1);
        check("timeout_amt", bus.change_amt, 5);
        do_change(5);
        credit = 0;
        wait_idle();
        check("timeout_credit", credit_reg, 0);
`else
        seen = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (bus.change_valid) seen = 1'b1;
        end
        #1;
        check("hold_no_refund", seen, 0);
        check("hold_credit", credit_reg, 5);
        check("hold_idle", bus.coin_ready, 1);
`endif

        check("load_clear_exclusive", mutex_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
